// File: rtl/sync_fifo_write_ptr.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_write_ptr
// Brief    : Write-side pointer, accept logic and status flags for a
//            single-clock FIFO, with sticky overflow and a high-water mark.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_write_ptr #(
    parameter int DEPTH        = 4,
    parameter int PTR_WIDTH    = $clog2(DEPTH) + 1,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [PTR_WIDTH-1:0] r_ptr,
    output logic [PTR_WIDTH-1:0] w_ptr,
    output logic [PTR_WIDTH-2:0] waddr,
    output logic                 mem_wen,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH-1:0] count,
    output logic                 overflow,
    input  logic                 clr_stat,
    output logic [PTR_WIDTH-1:0] high_water
);

    localparam logic [PTR_WIDTH-1:0] c_afull_thresh = PTR_WIDTH'(AFULL_THRESH);
    localparam logic [PTR_WIDTH-1:0] c_ptr_one      = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] r_w_ptr;
    logic                 r_overflow;
    logic [PTR_WIDTH-1:0] r_high_water;

    logic                 w_full;
    logic                 w_accept;
    logic [PTR_WIDTH-1:0] w_count;

    // Equal addresses with differing wrap bits means a full lap ahead of the reader.
    assign w_full   = (r_w_ptr[PTR_WIDTH-1] != r_ptr[PTR_WIDTH-1]) &&
                      (r_w_ptr[PTR_WIDTH-2:0] == r_ptr[PTR_WIDTH-2:0]);
    assign w_count  = r_w_ptr - r_ptr;
    assign w_accept = wen & ~w_full & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_ptr <= '0;
        end else if (w_accept) begin
            r_w_ptr <= r_w_ptr + c_ptr_one;
        end
    end

    // A fresh overflow in the clearing cycle must not be lost, so set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wen & w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_stat) begin
            r_overflow <= 1'b0;
        end
    end

    // Clearing restarts tracking from the present occupancy rather than zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_high_water <= '0;
        end else if (clr_stat) begin
            r_high_water <= w_count;
        end else if (w_count > r_high_water) begin
            r_high_water <= w_count;
        end
    end

    assign w_ptr       = r_w_ptr;
    assign waddr       = r_w_ptr[PTR_WIDTH-2:0];
    assign mem_wen     = w_accept;
    assign full        = w_full;
    assign count       = w_count;
    assign almost_full = (w_count >= c_afull_thresh);
    assign overflow    = r_overflow;
    assign high_water  = r_high_water;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_write_ptr.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_write_ptr
// Brief    : Directed self-checking bench for sync_fifo_write_ptr (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_write_ptr;

    localparam int DEPTH = 4;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen;
    logic          clr_stat;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr;
    logic [PW-2:0] waddr;
    logic          mem_wen;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] count;
    logic          overflow;
    logic [PW-1:0] high_water;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_write_ptr #(
        .DEPTH        (DEPTH),
        .PTR_WIDTH    (PW),
        .AFULL_THRESH (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .r_ptr       (r_ptr),
        .w_ptr       (w_ptr),
        .waddr       (waddr),
        .mem_wen     (mem_wen),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .clr_stat    (clr_stat),
        .high_water  (high_water)
    );

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b1; clr_stat = 1'b0; r_ptr = '0;
        step();
        n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wen: got %0b want 0", mem_wen); end
        step();
        rst = 1'b0; wen = 1'b0;
        #1;
        n_cmp++; if (w_ptr !== 3'd0) begin n_bad++; $display("FAIL reset_w_ptr: got %0d want 0", w_ptr); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b want 0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_afull: got %0b want 0", almost_full); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_cmp++; if (high_water !== 3'd0) begin n_bad++; $display("FAIL reset_hw: got %0d want 0", high_water); end
    endtask

    task automatic test_fill();
        logic [PW-2:0] exp_addr;
        logic [PW-1:0] exp_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            wen = 1'b1;
            #1;
            exp_addr = PW'(i);
            exp_cnt  = PW'(i);
            n_cmp++; if (mem_wen !== 1'b1) begin n_bad++; $display("FAIL fill_mem_wen[%0d]: got %0b want 1", i, mem_wen); end
            n_cmp++; if (waddr !== exp_addr) begin n_bad++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, waddr, exp_addr); end
            n_cmp++; if (count !== exp_cnt) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, exp_cnt); end
            n_cmp++; if (almost_full !== (i >= 3)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %0b want %0b", i, almost_full, (i >= 3)); end
        end
        step();
        n_cmp++; if (w_ptr !== 3'b100) begin n_bad++; $display("FAIL fill_w_ptr: got %0d want 4", w_ptr); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %0b want 1", full); end
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count_full: got %0d want 4", count); end
        n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL fill_5th_mem_wen: got %0b want 0", mem_wen); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow_early: got %0b want 0", overflow); end
        step();
        wen = 1'b0;
        #1;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_overflow: got %0b want 1", overflow); end
        n_cmp++; if (high_water !== 3'd4) begin n_bad++; $display("FAIL fill_hw: got %0d want 4", high_water); end
        n_cmp++; if (w_ptr !== 3'd4) begin n_bad++; $display("FAIL fill_refused_ptr: got %0d want 4", w_ptr); end
    endtask

    task automatic test_full_read();
        step();
        wen = 1'b1; r_ptr = 3'd0;
        #1;
        n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL fullrd_refused: got %0b want 0", mem_wen); end
        step();
        r_ptr = 3'd1;
        #1;
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL fullrd_full_drop: got %0b want 0", full); end
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fullrd_count: got %0d want 3", count); end
        n_cmp++; if (mem_wen !== 1'b1) begin n_bad++; $display("FAIL fullrd_accept: got %0b want 1", mem_wen); end
        n_cmp++; if (waddr !== 2'd0) begin n_bad++; $display("FAIL fullrd_waddr: got %0d want 0", waddr); end
        step();
        wen = 1'b0;
        #1;
        n_cmp++; if (w_ptr !== 3'd5) begin n_bad++; $display("FAIL fullrd_w_ptr: got %0d want 5", w_ptr); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fullrd_full_again: got %0b want 1", full); end
    endtask

    task automatic test_almost_full();
        step();
        r_ptr = 3'd3;
        #1;
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL afull_count2: got %0d want 2", count); end
        n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL afull_low: got %0b want 0", almost_full); end
        wen = 1'b1;
        step();
        wen = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL afull_count3: got %0d want 3", count); end
        n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL afull_rise: got %0b want 1", almost_full); end
        step();
        r_ptr = 3'd4;
        #1;
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL afull_count_back: got %0d want 2", count); end
        n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL afull_drop: got %0b want 0", almost_full); end
    endtask

    task automatic test_wrap();
        step();
        wen = 1'b1;
        #1;
        n_cmp++; if (waddr !== 2'd2) begin n_bad++; $display("FAIL wrap_waddr6: got %0d want 2", waddr); end
        step();
        n_cmp++; if (waddr !== 2'd3 || mem_wen !== 1'b1) begin n_bad++; $display("FAIL wrap_waddr7: got %0d/%0b want 3/1", waddr, mem_wen); end
        step();
        wen = 1'b0;
        #1;
        n_cmp++; if (w_ptr !== 3'd0) begin n_bad++; $display("FAIL wrap_w_ptr: got %0d want 0", w_ptr); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL wrap_full: got %0b want 1", full); end
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", count); end
        n_cmp++; if (waddr !== 2'd0) begin n_bad++; $display("FAIL wrap_waddr0: got %0d want 0", waddr); end
    endtask

    task automatic test_clear_stats();
        step();
        wen = 1'b1; clr_stat = 1'b1;
        step();
        wen = 1'b0; clr_stat = 1'b0;
        #1;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL clr_set_wins: got %0b want 1", overflow); end
        r_ptr = 3'd7;
        step();
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL clr_count: got %0d want 1", count); end
        n_cmp++; if (high_water !== 3'd4) begin n_bad++; $display("FAIL clr_hw_before: got %0d want 4", high_water); end
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        #1;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_overflow: got %0b want 0", overflow); end
        n_cmp++; if (high_water !== 3'd1) begin n_bad++; $display("FAIL clr_hw_after: got %0d want 1", high_water); end
    endtask

    task automatic test_reset_mid_burst();
        step();
        wen = 1'b1;
        #1;
        n_cmp++; if (mem_wen !== 1'b1 || waddr !== 2'd0) begin n_bad++; $display("FAIL mid_burst0: got %0b/%0d want 1/0", mem_wen, waddr); end
        step();
        n_cmp++; if (mem_wen !== 1'b1 || waddr !== 2'd1) begin n_bad++; $display("FAIL mid_burst1: got %0b/%0d want 1/1", mem_wen, waddr); end
        step();
        rst = 1'b1; r_ptr = 3'd0;
        #1;
        n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL mid_rst_mem_wen0: got %0b want 0", mem_wen); end
        step();
        n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL mid_rst_mem_wen1: got %0b want 0", mem_wen); end
        step();
        rst = 1'b0; wen = 1'b0;
        #1;
        n_cmp++; if (w_ptr !== 3'd0) begin n_bad++; $display("FAIL mid_rst_w_ptr: got %0d want 0", w_ptr); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_rst_overflow: got %0b want 0", overflow); end
        n_cmp++; if (high_water !== 3'd0) begin n_bad++; $display("FAIL mid_rst_hw: got %0d want 0", high_water); end
        n_cmp++; if (count !== 3'd0 || full !== 1'b0) begin n_bad++; $display("FAIL mid_rst_count_full: got %0d/%0b want 0/0", count, full); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_read();
        test_almost_full();
        test_wrap();
        test_clear_stats();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_write_ptr.md
# sync_fifo_write_ptr

Write-side pointer and flag controller for the synchronous FIFO; the write-end counterpart of the FIFO read-pointer block. It owns the extended write pointer and decides when a write is accepted. It drives the storage write strobe and address, and produces the full, almost-full and occupancy status. It also keeps a sticky overflow flag and a clearable high-water mark for debug and monitoring. It sits between the producer and the FIFO storage array and exchanges pointers with the read-pointer block over a single clock domain.

## Interface
- depth, 4: number of entries; must be a power of two and at least 2
- ptr_width, $clog2(depth)+1: extended pointer width; the MSB is the wrap bit
- afull_thresh, depth-1: occupancy at or above which almost_full asserts; legal range 1..depth

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wen  input  1  producer write request
- r_ptr  input  ptr_width  read pointer from the read-pointer block
- w_ptr  output  ptr_width  registered extended write pointer
- waddr  output  ptr_width-1  storage write address, equal to w_ptr[ptr_width-2:0]
- mem_wen  output  1  storage write strobe, meaning the write is accepted this cycle
- full  output  1  FIFO full
- almost_full  output  1  count >= afull_thresh
- count  output  ptr_width  occupancy, 0..depth
- overflow  output  1  sticky flag for a write attempted while full
- clr_stat  input  1  clears overflow and high_water
- high_water  output  ptr_width  maximum count observed since the last clear

## Operation
- Write accept:
  - mem_wen = wen & ~full & ~rst.
  - On each accepted write, w_ptr increments by 1 modulo 2^ptr_width on the next edge.
  - A refused write leaves w_ptr unchanged and drops the data.
- full = (w_ptr[MSB] != r_ptr[MSB]) && (w_ptr[MSB-1:0] == r_ptr[MSB-1:0]). This is combinational from the registered w_ptr and the input r_ptr.
- count = w_ptr - r_ptr, computed modulo 2^ptr_width. It is never greater than depth.
- almost_full = (count >= afull_thresh), combinational.
- Overflow:
  - Set on any cycle with wen & full & ~rst.
  - Cleared by clr_stat.
  - If set and clear occur in the same cycle, set wins and overflow = 1.
- High-water mark:
  - Each edge, high_water <= max(high_water, count).
  - On clr_stat, high_water <= count, the current occupancy, not 0.
- Wrap-around: w_ptr wraps from 2*depth-1 to 0. The wrap bit toggles every depth writes, which is what lets full be told apart from empty.
- Full with a simultaneous read: the write is still refused that cycle, because full is evaluated against the current r_ptr. The producer retries next cycle. There is no write-through-on-read.

## Timing
- Reset (rst = 1 at an edge) sets w_ptr = 0, overflow = 0, high_water = 0.
- After reset, with the read side also reset: full = 0, almost_full = 0, count = 0.
- While rst = 1, mem_wen = 0 regardless of wen.
- A reset asserted mid-stream discards the pointer state; the read block's r_ptr resets in the same cycle.
- Write latency: mem_wen and waddr are valid in the same cycle as wen. w_ptr, count and full reflect the write one cycle later.
- A read visible on r_ptr updates full, count and almost_full combinationally in that same cycle.
- The read block's empty flag sees an accepted write one cycle after mem_wen, when w_ptr updates.
- overflow and high_water are registered and visible one cycle after the triggering event.

## Test plan
- Reset, then depth=4 and 4 consecutive writes with r_ptr=0:
  - mem_wen is 1 on all 4 cycles and waddr runs 0,1,2,3.
  - w_ptr ends at 4 (binary 100); full=1 and count=4.
  - A 5th wen gives mem_wen=0, and overflow=1 on the next cycle.
- Wrap: interleave writes and reads so that w_ptr passes 7 to 0. At w_ptr=0 with r_ptr=4: full=1, count=4, waddr=0.
- Full plus a same-cycle read: with w_ptr=4, r_ptr=0 and wen=1, mem_wen=0 that cycle. With r_ptr=1 on the next cycle, a write is accepted and w_ptr becomes 5.
- afull_thresh=3: count steps 2 to 3 and almost_full rises on the same cycle as count=3. A read back to count=2 drops it.
- clr_stat with a simultaneous overflow condition: overflow stays 1. A later clr_stat with no write gives overflow=0, and high_water becomes the current count (for example 1) while the previous maximum was 4.
- rst asserted mid-burst with wen=1: mem_wen=0 during rst. After release, w_ptr=0, overflow=0, high_water=0.
